// File: rtl/des_cbc_chainer_if.sv
// Block stream between a plaintext source, the chainer and a ciphertext sink.
// The slave side is the chainer; the master side is whoever feeds and drains it.
interface des_cbc_chainer_if;
    logic        mode;       // 0 = ECB, 1 = CBC
    logic        iv_load;
    logic [63:0] iv;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_block;

    modport master (
        output mode, iv_load, iv, in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  mode, iv_load, iv, in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/des_cbc_chainer.sv
// ECB/CBC mode controller in front of a DES core. One block in flight:
// accept, hold the plaintext for DES_LATENCY cycles, capture the ciphertext,
// present it until the sink takes it. The key path bypasses this block.
module des_cbc_chainer #(
    parameter int DES_LATENCY = 1      // legal range 1..255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    des_cbc_chainer_if.slave  bus,
    output logic [63:0]       des_pt_o,
    input  logic [63:0]       des_ct_i,
    output logic              busy_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

    // Counter value on the cycle whose closing edge samples the DES output.
    localparam logic [7:0] LAST_CNT = 8'(DES_LATENCY - 1);

    state_t      state_q, state_d;
    logic [63:0] des_pt_q, des_pt_d;
    logic [63:0] chain_q, chain_d;
    logic [63:0] out_block_q, out_block_d;
    logic        out_valid_q, out_valid_d;
    logic        mode_q, mode_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [63:0] chain_sel;

    // A same-cycle IV load takes effect for the block accepted alongside it.
    assign chain_sel = bus.iv_load ? bus.iv : chain_q;

    assign bus.in_ready  = (state_q == S_IDLE) && !rst_i;
    assign bus.out_valid = out_valid_q;
    assign bus.out_block = out_block_q;
    assign des_pt_o      = des_pt_q;
    assign busy_o        = (state_q != S_IDLE);

    // Next-state and datapath decisions for the accept / wait / present cycle.
    always_comb begin
        state_d     = state_q;
        des_pt_d    = des_pt_q;
        chain_d     = chain_q;
        out_block_d = out_block_q;
        out_valid_d = out_valid_q;
        mode_d      = mode_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.iv_load) begin
                    chain_d = bus.iv;
                end
                if (bus.in_valid) begin
                    des_pt_d = bus.in_block ^ (bus.mode ? chain_sel : 64'd0);
                    mode_d   = bus.mode;
                    cnt_d    = 8'd0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    out_block_d = des_ct_i;
                    out_valid_d = 1'b1;
                    // ECB blocks never disturb the chaining value.
                    if (mode_q) begin
                        chain_d = des_ct_i;
                    end
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset drops any in-flight block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            des_pt_q    <= 64'd0;
            chain_q     <= 64'd0;
            out_block_q <= 64'd0;
            out_valid_q <= 1'b0;
            mode_q      <= 1'b0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            des_pt_q    <= des_pt_d;
            chain_q     <= chain_d;
            out_block_q <= out_block_d;
            out_valid_q <= out_valid_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_des_cbc_chainer.sv
// Bench for des_cbc_chainer: table of chained blocks plus hand-written
// backpressure, busy IV load, mid-WAIT reset and DES_LATENCY=4 sequences.
module tb_des_cbc_chainer;
    localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
    localparam logic [63:0] P_REF = 64'h0123456789ABCDEF;
    localparam logic [63:0] C_REF = 64'h85E813540F0AB405;
    localparam logic [63:0] P_2ND = 64'h84CB563386A179EA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Stand-in for DES_top keyed with KEY: returns the reference ciphertext
    // for the reference plaintext and an easily hand-computed mix otherwise.
    function automatic logic [63:0] des_stub(input logic [63:0] pt);
        if (pt == P_REF) return C_REF;
        return {pt[31:0], pt[63:32]} ^ KEY;
    endfunction

    des_cbc_chainer_if bus1 ();
    des_cbc_chainer_if bus4 ();
    logic [63:0] pt1, ct1, pt4, ct4;
    logic        busy1, busy4;
    assign ct1 = des_stub(pt1);
    assign ct4 = des_stub(pt4);

    des_cbc_chainer #(.DES_LATENCY(1)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus1),
        .des_pt_o(pt1), .des_ct_i(ct1), .busy_o(busy1)
    );

    des_cbc_chainer #(.DES_LATENCY(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .bus(bus4),
        .des_pt_o(pt4), .des_ct_i(ct4), .busy_o(busy4)
    );

    typedef struct {
        logic        mode;
        logic        iv_load;
        logic [63:0] iv;
        logic [63:0] blk;
        logic [63:0] exp_pt;
        logic [63:0] exp_ct;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One complete block on the DES_LATENCY=1 instance, acknowledged at once.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        bus1.mode     = v.mode;
        bus1.iv_load  = v.iv_load;
        bus1.iv       = v.iv;
        bus1.in_block = v.blk;
        bus1.in_valid = 1'b1;
        bus1.out_ready = 1'b0;
        check1({tag, " in_ready"}, bus1.in_ready, 1'b1);
        tick();
        bus1.in_valid = 1'b0;
        bus1.iv_load  = 1'b0;
        bus1.in_block = {$urandom, $urandom};
        check64({tag, " des_pt"}, pt1, v.exp_pt);
        check1({tag, " busy"}, busy1, 1'b1);
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            tick();
            n++;
        end
        check64({tag, " latency"}, 64'(n), 64'd1);
        check64({tag, " out_block"}, bus1.out_block, v.exp_ct);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check1({tag, " out_valid drop"}, bus1.out_valid, 1'b0);
        check64({tag, " out_block kept"}, bus1.out_block, v.exp_ct);
        check1({tag, " idle"}, busy1, 1'b0);
        $display("[TB] %s mode=%0d pt=%h ct=%h", tag, v.mode, pt1, bus1.out_block);
    endtask

    initial begin
        // Chained sequence: state carries from one entry to the next.
        vecs[0] = '{1'b0, 1'b0, 64'd0, P_REF, P_REF, C_REF};                    // ECB
        vecs[1] = '{1'b1, 1'b1, 64'd0, P_REF, P_REF, C_REF};                    // CBC, IV=0
        vecs[2] = '{1'b1, 1'b0, 64'd0, P_2ND, P_REF, C_REF};                    // chained
        vecs[3] = '{1'b0, 1'b0, 64'd0, P_2ND, P_2ND, 64'h95952E931F7789C2};     // ECB leaves CHAIN
        vecs[4] = '{1'b1, 1'b0, 64'd0, P_2ND, P_REF, C_REF};                    // CHAIN still C_REF
        vecs[5] = '{1'b1, 1'b1, P_REF, P_REF, 64'd0, KEY};                      // same-cycle IV
        vecs[6] = '{1'b1, 1'b0, 64'd0, 64'h1217121E1217121E, P_REF, C_REF};     // chain = KEY

        bus1.mode = 0; bus1.iv_load = 0; bus1.iv = 0; bus1.in_valid = 0;
        bus1.in_block = 0; bus1.out_ready = 0;
        bus4.mode = 0; bus4.iv_load = 0; bus4.iv = 0; bus4.in_valid = 0;
        bus4.in_block = 0; bus4.out_ready = 0;

        tick(); tick();
        check1("rst in_ready", bus1.in_ready, 1'b0);
        check1("rst out_valid", bus1.out_valid, 1'b0);
        check64("rst out_block", bus1.out_block, 64'd0);
        check64("rst des_pt", pt1, 64'd0);
        check1("rst busy", busy1, 1'b0);
        rst = 1'b0;
        #1;
        check1("post-rst in_ready", bus1.in_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure with a busy IV load and a waiting producer.
        bus1.mode = 1'b1; bus1.in_block = P_2ND; bus1.in_valid = 1'b1;
        tick();
        check64("bp des_pt", pt1, P_REF);
        bus1.iv_load = 1'b1; bus1.iv = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check1("bp out_valid up", bus1.out_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check1($sformatf("bp%0d out_valid", c), bus1.out_valid, 1'b1);
            check64($sformatf("bp%0d out_block", c), bus1.out_block, C_REF);
            check1($sformatf("bp%0d in_ready", c), bus1.in_ready, 1'b0);
            check1($sformatf("bp%0d busy", c), busy1, 1'b1);
        end
        bus1.iv_load = 1'b0;
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check1("bp release out_valid", bus1.out_valid, 1'b0);
        check1("bp release in_ready", bus1.in_ready, 1'b1);
        check1("bp release busy", busy1, 1'b0);
        tick();
        bus1.in_valid = 1'b0;
        check1("bp reaccept busy", busy1, 1'b1);
        check64("bp iv ignored des_pt", pt1, P_REF);
        tick();
        check1("bp2 out_valid", bus1.out_valid, 1'b1);
        check64("bp2 out_block", bus1.out_block, C_REF);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        $display("[TB] backpressure/iv-busy sequence done, out=%h", bus1.out_block);

        // Reset in WAIT: CHAIN is C_REF here, so the CBC block first sees P_2ND.
        bus1.mode = 1'b1; bus1.in_block = P_REF; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check64("rw des_pt", pt1, P_2ND);
        rst = 1'b1;
        tick();
        check1("rw out_valid", bus1.out_valid, 1'b0);
        check64("rw des_pt cleared", pt1, 64'd0);
        check1("rw in_ready in rst", bus1.in_ready, 1'b0);
        check1("rw busy", busy1, 1'b0);
        rst = 1'b0;
        #1;
        check1("rw in_ready released", bus1.in_ready, 1'b1);
        run_vec('{1'b1, 1'b0, 64'd0, P_REF, P_REF, C_REF}, "after-rst");

        // DES_LATENCY=4 instance: output appears after the 4th edge past accept.
        bus4.mode = 1'b0; bus4.in_block = P_REF; bus4.in_valid = 1'b1;
        check1("l4 in_ready", bus4.in_ready, 1'b1);
        tick();
        bus4.in_valid = 1'b0;
        check64("l4 des_pt", pt4, P_REF);
        for (int n = 1; n <= 4; n++) begin
            tick();
            check1($sformatf("l4 edge%0d out_valid", n), bus4.out_valid, n == 4);
        end
        check64("l4 out_block", bus4.out_block, C_REF);
        bus4.out_ready = 1'b1;
        tick();
        bus4.out_ready = 1'b0;
        check1("l4 out_valid drop", bus4.out_valid, 1'b0);
        $display("[TB] latency4 ecb pt=%h ct=%h", pt4, bus4.out_block);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
